occ_ram_accum: RTL and testbench
================================

# occ_ram_accum

Parametrised occupancy accumulator that owns the FPGA-side port of the dual-port occupancy on-chip RAM, while the HPS reads histograms through the other port. It merges hit streams from N_CH channels with a round-robin arbiter and performs one read-modify-write increment per hit. It also provides a full-RAM clear sweep and total/saturation counters. It generalises the fixed 7-bit-address, 8-bit-data, single-writer occupancy port to configurable width, depth and channel count.

## Interface
- ADDR_W, 7, RAM address width; depth = 2^ADDR_W
- DATA_W, 8, RAM word / bin counter width
- N_CH, 4, hit input channels (1..16)
- clk_clk  in  1  single clock; RAM port clock tied to it
- reset_reset  in  1  synchronous, active-high reset
- hit_valid  in  N_CH  per-channel hit request
- hit_addr  in  N_CH*ADDR_W  bin address; channel i at [i*ADDR_W +: ADDR_W]
- hit_ready  out  N_CH  one-hot grant; a hit transfers when valid & ready
- clear_req  in  1  pulse: request zeroing of all bins
- busy  out  1  high in any state other than IDLE
- clear_done  out  1  one-cycle pulse after the last clear write
- ram_address  out  ADDR_W  RAM port address
- ram_chipselect  out  1  RAM port select
- ram_clken  out  1  RAM clock enable
- ram_write  out  1  RAM write strobe
- ram_writedata  out  DATA_W  RAM write data
- ram_readdata  in  DATA_W  RAM read data, valid 1 cycle after a read
- hit_count  out  32  accepted hits, wraps at 2^32
- sat_count  out  32  increments suppressed by saturation, saturating at 2^32-1

## Operation
- States: IDLE, RD, WR, CLR.
- IDLE:
  - If clear_req is pending, go to CLR; clear has priority over hits.
  - Else if any hit_valid, grant one channel (hit_ready pulses), latch its address, go to RD.
- RD: ram_chipselect=1, ram_write=0, ram_address=latched address; go to WR.
- WR: ram_readdata is valid.
  - ram_writedata = readdata+1; ram_write=1, chipselect=1, same address.
  - Same cycle, accept a new hit if no clear is pending and any hit_valid (go to RD); else IDLE, or CLR if a clear is pending.
- Hits may be accepted only in IDLE or WR, so sustained throughput is 1 hit per 2 cycles.
- CLR: write 0 to addresses 0..2^ADDR_W-1, one per cycle in ascending order.
  - hit_ready=0 throughout.
  - clear_done pulses the cycle after the final write; then return to IDLE.
- clear_req:
  - Latched into a pending flag when seen in any state.
  - A request arriving during RD lets the RMW finish its WR first.
  - A request during CLR is absorbed; no second sweep.
- Round-robin arbitration: after granting channel g, search priority starts at (g+1) mod N_CH.
- hit_count increments on every accepted hit.
- ram_clken = 1 whenever not in reset.

## Timing
- Reset values:
  - All outputs 0, including ram_clken.
  - State IDLE; RR pointer 0; clear-pending flag 0.
  - Counters 0; RAM contents untouched.
- Grant to RAM read: 1 cycle; grant to RAM write: 2 cycles.
- Reset asserted mid-RMW or mid-CLR aborts immediately:
  - No further writes.
  - A partially cleared RAM stays partial, and clear_done is not pulsed.
- Simultaneous hit_valid and clear_req in IDLE: clear wins; no hit_ready.
- Address 2^ADDR_W-1 is the last clear write; the clear address counter is ADDR_W+1 bits so the terminal count is detectable without wrapping.

## Configuration
- OCC_RAM_ACCUM_SAT_EN:
  - Defined: a bin at 2^DATA_W-1 is rewritten unchanged, and sat_count increments.
  - Undefined: the increment wraps modulo 2^DATA_W, and sat_count is tied to 0.

## Structure
- occ_pkg holds:
  - state enum (IDLE, RD, WR, CLR)
  - default ADDR_W/DATA_W/N_CH localparams
  - counter width constant (32)
- Sub-module occ_rr_arb: N_CH-wide round-robin arbiter.
  - Inputs: request vector, advance strobe.
  - Outputs: one-hot grant and grant index; pointer state lives inside.

## Test plan
- Reset, then a single hit on ch0 addr 5 with bin=3 -> RAM read of 5 at T+1, write of 4 at T+2; hit_count=1.
- All 4 channels valid continuously at distinct addrs -> grants 0,1,2,3,0 on cycles T, T+2, T+4, ...; each bin +1 per grant.
- Bin preloaded 255, DATA_W=8, one hit -> with SAT_EN: written 255, sat_count=1; without: written 0, sat_count=0.
- clear_req during RD -> WR completes, then 128 zero writes at addrs 0..127, clear_done pulses once, no hit_ready during CLR.
- reset_reset at clear address 40 -> no further writes, busy=0 next cycle, addrs 41..127 keep old values, no clear_done.
- Same address hit back-to-back from ch1 and ch2 -> second read sees first write; bin increments by 2 total.

Source files
------------

// File: rtl/occ_pkg.sv
// Shared types and default sizes for the occupancy RAM accumulator.
package occ_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, CLR} state_t;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_CH   = 4;
  localparam int CNT_W      = 32;

  // Index width that stays legal for a single channel.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/occ_ram_accum_if.sv
// Hit stream and FPGA-side occupancy RAM port, bundled for the accumulator.
interface occ_ram_accum_if
  import occ_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CH   = DEF_N_CH
) ();
  logic [N_CH-1:0]        hit_valid;
  logic [N_CH*ADDR_W-1:0] hit_addr;
  logic [N_CH-1:0]        hit_ready;
  logic [ADDR_W-1:0]      ram_address;
  logic                   ram_chipselect;
  logic                   ram_clken;
  logic                   ram_write;
  logic [DATA_W-1:0]      ram_writedata;
  logic [DATA_W-1:0]      ram_readdata;

  modport slave (
    input  hit_valid, hit_addr, ram_readdata,
    output hit_ready, ram_address, ram_chipselect, ram_clken, ram_write, ram_writedata
  );

  modport master (
    output hit_valid, hit_addr, ram_readdata,
    input  hit_ready, ram_address, ram_chipselect, ram_clken, ram_write, ram_writedata
  );
endinterface

// File: rtl/occ_rr_arb.sv
// Round-robin arbiter: after a grant, the search starts one past the granted channel.
module occ_rr_arb
  import occ_pkg::*;
#(
  parameter  int N_CH  = DEF_N_CH,
  localparam int IDX_W = idx_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic             advance,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);
  logic [IDX_W-1:0] ptr;

  always_comb begin
    int   j;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int off = 0; off < N_CH; off++) begin
      j = int'(ptr) + off;
      if (j >= N_CH) j = j - N_CH;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/occ_ram_accum.sv
// Occupancy accumulator: round-robin hit merge, read-modify-write bin increment, clear sweep.
// Define OCC_RAM_ACCUM_SAT_EN to hold full bins at all-ones and count suppressed increments.
module occ_ram_accum
  import occ_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CH   = DEF_N_CH
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  occ_ram_accum_if.slave   bus,
  input  logic             clear_req,
  output logic             busy,
  output logic             clear_done,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] sat_count
);
  localparam int IDX_W = idx_w(N_CH);

  state_t            state, state_next;
  logic              clr_pend, clr_any, any_hit, accept, clr_last, clken_q;
  logic [ADDR_W-1:0] addr_q, hit_sel;
  logic [ADDR_W:0]   clr_cnt;
  logic [N_CH-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic [DATA_W-1:0] incr;

  occ_rr_arb #(.N_CH(N_CH)) u_arb (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .req       (bus.hit_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A clear seen this cycle counts as pending so it beats a simultaneous hit.
  assign clr_any       = clr_pend | clear_req;
  assign any_hit       = |bus.hit_valid;
  assign clr_last      = clr_cnt[ADDR_W];
  assign accept        = !reset_reset && (state == IDLE || state == WR) && !clr_any && any_hit;
  assign hit_sel       = bus.hit_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign bus.hit_ready = accept ? grant : '0;
  assign bus.ram_clken = clken_q;
  assign busy          = !reset_reset && (state != IDLE);
  assign clear_done    = !reset_reset && (state == CLR) && clr_last;

`ifdef OCC_RAM_ACCUM_SAT_EN
  logic bin_full;
  assign bin_full = &bus.ram_readdata;
  assign incr     = bin_full ? bus.ram_readdata : bus.ram_readdata + DATA_W'(1);
`else
  assign incr     = bus.ram_readdata + DATA_W'(1);
`endif

  always_comb begin
    state_next         = state;
    bus.ram_address    = '0;
    bus.ram_chipselect = 1'b0;
    bus.ram_write      = 1'b0;
    bus.ram_writedata  = '0;
    case (state)
      IDLE: begin
        if (clr_any)      state_next = CLR;
        else if (any_hit) state_next = RD;
      end
      RD: begin
        bus.ram_chipselect = 1'b1;
        bus.ram_address    = addr_q;
        state_next         = WR;
      end
      WR: begin
        bus.ram_chipselect = 1'b1;
        bus.ram_write      = 1'b1;
        bus.ram_address    = addr_q;
        bus.ram_writedata  = incr;
        if (clr_any)      state_next = CLR;
        else if (any_hit) state_next = RD;
        else              state_next = IDLE;
      end
      CLR: begin
        // The extra counter bit marks the done cycle after the last write.
        if (!clr_last) begin
          bus.ram_chipselect = 1'b1;
          bus.ram_write      = 1'b1;
          bus.ram_address    = clr_cnt[ADDR_W-1:0];
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (reset_reset) begin
      bus.ram_chipselect = 1'b0;
      bus.ram_write      = 1'b0;
      bus.ram_address    = '0;
      bus.ram_writedata  = '0;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state     <= IDLE;
      clr_pend  <= 1'b0;
      addr_q    <= '0;
      clr_cnt   <= '0;
      hit_count <= '0;
      clken_q   <= 1'b0;
    end else begin
      state   <= state_next;
      clken_q <= 1'b1;
      if (state_next == CLR || state == CLR) clr_pend <= 1'b0;
      else if (clear_req)                    clr_pend <= 1'b1;
      if (accept) begin
        addr_q    <= hit_sel;
        hit_count <= hit_count + CNT_W'(1);
      end
      clr_cnt <= (state == CLR) ? clr_cnt + (ADDR_W+1)'(1) : '0;
    end
  end

`ifdef OCC_RAM_ACCUM_SAT_EN
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sat_count <= '0;
    end else if (state == WR && bin_full && !(&sat_count)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end
`else
  assign sat_count = '0;
`endif
endmodule

// File: tb/tb_occ_ram_accum.sv
// Self-checking bench for occ_ram_accum: a RAM model plus a scoreboard of expected bin writes.
module tb_occ_ram_accum;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int N_CH   = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct { int cyc; int addr; int data; } acc_t;
  typedef struct { int addr; int data; } exp_t;
  typedef struct { int cyc; logic [N_CH-1:0] vec; } gr_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset, clear_req, busy, clear_done;
  logic [31:0] hit_count, sat_count;

  occ_ram_accum_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_CH(N_CH)) bus ();

  occ_ram_accum #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_CH(N_CH)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .bus         (bus),
    .clear_req   (clear_req),
    .busy        (busy),
    .clear_done  (clear_done),
    .hit_count   (hit_count),
    .sat_count   (sat_count)
  );

  logic [DATA_W-1:0] mem   [DEPTH];
  logic [DATA_W-1:0] model [DEPTH];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;
  int cyc = 0, n_checks = 0, n_pass = 0, done_cnt = 0, done_cyc = -1;
  acc_t wr_q[$];
  acc_t rd_q[$];
  gr_t  gr_q[$];
  exp_t exp_q[$];

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  // RAM with one-cycle read latency; the preload port lets the bench seed bins.
  always @(posedge clk_clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.ram_chipselect && bus.ram_clken) begin
      if (bus.ram_write) mem[bus.ram_address] <= bus.ram_writedata;
      else               bus.ram_readdata     <= mem[bus.ram_address];
    end
  end

  always @(negedge clk_clk) begin
    if (bus.ram_chipselect && bus.ram_write)
      wr_q.push_back('{cyc, int'(bus.ram_address), int'(bus.ram_writedata)});
    if (bus.ram_chipselect && !bus.ram_write)
      rd_q.push_back('{cyc, int'(bus.ram_address), 0});
    if (|bus.hit_ready) gr_q.push_back('{cyc, bus.hit_ready});
    if (clear_done) begin done_cnt++; done_cyc = cyc; end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset;
    reset_reset = 1'b1; clear_req = 1'b0; bus.hit_valid = '0; bus.hit_addr = '0;
    repeat (3) @(posedge clk_clk);
    #1 reset_reset = 1'b0;
    @(posedge clk_clk); #1;
    wr_q.delete(); rd_q.delete(); gr_q.delete(); exp_q.delete();
    done_cnt = 0; done_cyc = -1;
  endtask

  task automatic preload(input int a, input int d);
    pre_we = 1'b1; pre_addr = ADDR_W'(a); pre_data = DATA_W'(d);
    @(posedge clk_clk); #1 pre_we = 1'b0;
    model[a] = DATA_W'(d);
  endtask

  task automatic test_reset;
    reset_reset = 1'b1; clear_req = 1'b1; bus.hit_valid = '1; bus.hit_addr = '0;
    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk);
    n_checks++; if (bus.hit_ready !== 4'b0) $display("FAIL rst_hit_ready: got %b want 0000", bus.hit_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (clear_done !== 1'b0) $display("FAIL rst_clear_done: got %b want 0", clear_done); else n_pass++;
    n_checks++; if (bus.ram_clken !== 1'b0) $display("FAIL rst_clken: got %b want 0", bus.ram_clken); else n_pass++;
    n_checks++; if (bus.ram_chipselect !== 1'b0) $display("FAIL rst_cs: got %b want 0", bus.ram_chipselect); else n_pass++;
    n_checks++; if (bus.ram_write !== 1'b0) $display("FAIL rst_write: got %b want 0", bus.ram_write); else n_pass++;
    n_checks++; if (hit_count !== 32'd0) $display("FAIL rst_hit_count: got %0d want 0", hit_count); else n_pass++;
    n_checks++; if (sat_count !== 32'd0) $display("FAIL rst_sat_count: got %0d want 0", sat_count); else n_pass++;
    @(posedge clk_clk); #1 reset_reset = 1'b0; clear_req = 1'b0; bus.hit_valid = '0;
    @(posedge clk_clk); @(negedge clk_clk);
    n_checks++; if (bus.ram_clken !== 1'b1) $display("FAIL run_clken: got %b want 1", bus.ram_clken); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL run_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single_hit;
    int t0; acc_t r, w; gr_t g; exp_t e;
    do_reset; preload(5, 3);
    bus.hit_addr[0 +: ADDR_W] = 7'd5; bus.hit_valid = 4'b0001; t0 = cyc;
    model[5] = model[5] + 8'd1; exp_q.push_back('{5, int'(model[5])});
    for (int i = 0; i < 10 && gr_q.size() == 0; i++) begin @(negedge clk_clk); #1; end
    @(posedge clk_clk); #1 bus.hit_valid = '0;
    for (int i = 0; i < 20 && wr_q.size() < 1; i++) begin @(negedge clk_clk); #1; end
    g = (gr_q.size() > 0) ? gr_q[0] : '{-1, '0};
    r = (rd_q.size() > 0) ? rd_q[0] : '{-1, -1, -1};
    w = (wr_q.size() > 0) ? wr_q[0] : '{-1, -1, -1};
    n_checks++; if (g.cyc !== t0 || g.vec !== 4'b0001) $display("FAIL single_grant: got cyc %0d vec %b want cyc %0d vec 0001", g.cyc, g.vec, t0); else n_pass++;
    n_checks++; if (r.cyc !== t0 + 1 || r.addr !== 5) $display("FAIL single_read: got cyc %0d addr %0d want cyc %0d addr 5", r.cyc, r.addr, t0 + 1); else n_pass++;
    n_checks++; if (w.cyc !== t0 + 2) $display("FAIL single_write_cyc: got %0d want %0d", w.cyc, t0 + 2); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      w = (wr_q.size() > 0) ? wr_q.pop_front() : '{-1, -1, -1};
      n_checks++; if (w.addr !== e.addr || w.data !== e.data) $display("FAIL single_sb: got %0d@%0d want %0d@%0d", w.data, w.addr, e.data, e.addr); else n_pass++;
    end
    n_checks++; if (hit_count !== 32'd1) $display("FAIL single_hit_count: got %0d want 1", hit_count); else n_pass++;
  endtask

  task automatic test_round_robin;
    int t0, c; acc_t w; gr_t g; exp_t e;
    do_reset;
    for (int ch = 0; ch < N_CH; ch++) begin
      preload(10 + ch, ch * 16);
      bus.hit_addr[ch*ADDR_W +: ADDR_W] = ADDR_W'(10 + ch);
    end
    bus.hit_valid = '1; t0 = cyc;
    for (int k = 0; k < 5; k++) begin
      c = k % N_CH;
      model[10 + c] = model[10 + c] + 8'd1;
      exp_q.push_back('{10 + c, int'(model[10 + c])});
    end
    for (int i = 0; i < 40 && gr_q.size() < 5; i++) begin @(negedge clk_clk); #1; end
    @(posedge clk_clk); #1 bus.hit_valid = '0;
    for (int i = 0; i < 20 && wr_q.size() < 5; i++) begin @(negedge clk_clk); #1; end
    for (int k = 0; k < 5; k++) begin
      g = (gr_q.size() > k) ? gr_q[k] : '{-1, '0};
      n_checks++;
      if (g.cyc !== t0 + 2 * k || g.vec !== N_CH'(1 << (k % N_CH)))
        $display("FAIL rr_grant%0d: got cyc %0d vec %b want cyc %0d ch %0d", k, g.cyc, g.vec, t0 + 2 * k, k % N_CH);
      else n_pass++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      w = (wr_q.size() > 0) ? wr_q.pop_front() : '{-1, -1, -1};
      n_checks++; if (w.addr !== e.addr || w.data !== e.data) $display("FAIL rr_sb: got %0d@%0d want %0d@%0d", w.data, w.addr, e.data, e.addr); else n_pass++;
    end
    n_checks++; if (hit_count !== 32'd5) $display("FAIL rr_hit_count: got %0d want 5", hit_count); else n_pass++;
  endtask

  task automatic test_saturation;
    int exp_sat; acc_t w; gr_t g; exp_t e;
    do_reset; preload(20, 255);
`ifdef OCC_RAM_ACCUM_SAT_EN
    model[20] = 8'd255; exp_sat = 1;
`else
    model[20] = 8'd0; exp_sat = 0;
`endif
    exp_q.push_back('{20, int'(model[20])});
    bus.hit_addr[2*ADDR_W +: ADDR_W] = 7'd20; bus.hit_valid = 4'b0100;
    for (int i = 0; i < 10 && gr_q.size() == 0; i++) begin @(negedge clk_clk); #1; end
    @(posedge clk_clk); #1 bus.hit_valid = '0;
    for (int i = 0; i < 20 && wr_q.size() < 1; i++) begin @(negedge clk_clk); #1; end
    g = (gr_q.size() > 0) ? gr_q[0] : '{-1, '0};
    n_checks++; if (g.vec !== 4'b0100) $display("FAIL sat_grant: got %b want 0100", g.vec); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      w = (wr_q.size() > 0) ? wr_q.pop_front() : '{-1, -1, -1};
      n_checks++; if (w.addr !== e.addr || w.data !== e.data) $display("FAIL sat_sb: got %0d@%0d want %0d@%0d", w.data, w.addr, e.data, e.addr); else n_pass++;
    end
    @(negedge clk_clk);
    n_checks++; if (sat_count !== 32'(exp_sat)) $display("FAIL sat_count: got %0d want %0d", sat_count, exp_sat); else n_pass++;
    n_checks++; if (mem[20] !== model[20]) $display("FAIL sat_bin: got %0d want %0d", mem[20], model[20]); else n_pass++;
  endtask

  task automatic test_clear_during_rd;
    int t0, nwr; acc_t w0, w1, w; exp_t e;
    do_reset; preload(30, 7);
    bus.hit_addr[0 +: ADDR_W] = 7'd30; bus.hit_valid = 4'b0001; t0 = cyc;
    model[30] = 8'd8; exp_q.push_back('{30, 8});
    for (int a = 0; a < DEPTH; a++) begin model[a] = '0; exp_q.push_back('{a, 0}); end
    for (int i = 0; i < 10 && gr_q.size() == 0; i++) begin @(negedge clk_clk); #1; end
    @(posedge clk_clk); #1;
    bus.hit_valid = 4'b1000; bus.hit_addr[3*ADDR_W +: ADDR_W] = 7'd99; clear_req = 1'b1;
    @(posedge clk_clk); #1 clear_req = 1'b0;
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin @(negedge clk_clk); #1; end
    @(posedge clk_clk); #1 bus.hit_valid = '0;
    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk); #1;
    nwr = wr_q.size();
    w0 = (nwr > 0) ? wr_q[0] : '{-1, -1, -1};
    w1 = (nwr > 1) ? wr_q[1] : '{-1, -1, -1};
    n_checks++; if (nwr !== DEPTH + 1) $display("FAIL clr_nwrites: got %0d want %0d", nwr, DEPTH + 1); else n_pass++;
    n_checks++; if (w0.cyc !== t0 + 2) $display("FAIL clr_rmw_cyc: got %0d want %0d", w0.cyc, t0 + 2); else n_pass++;
    n_checks++; if (w1.cyc !== t0 + 3) $display("FAIL clr_first_cyc: got %0d want %0d", w1.cyc, t0 + 3); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL clr_done_count: got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (done_cyc !== t0 + 3 + DEPTH) $display("FAIL clr_done_cyc: got %0d want %0d", done_cyc, t0 + 3 + DEPTH); else n_pass++;
    n_checks++; if (gr_q.size() !== 1) $display("FAIL clr_no_grant: got %0d grants want 1", gr_q.size()); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL clr_busy_after: got %b want 0", busy); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      w = (wr_q.size() > 0) ? wr_q.pop_front() : '{-1, -1, -1};
      n_checks++; if (w.addr !== e.addr || w.data !== e.data) $display("FAIL clr_sb: got %0d@%0d want %0d@%0d", w.data, w.addr, e.data, e.addr); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_clear;
    int found, bad_lo, bad_hi;
    do_reset;
    for (int a = 0; a < DEPTH; a++) preload(a, 8'hA5);
    clear_req = 1'b1;
    @(posedge clk_clk); #1 clear_req = 1'b0;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(negedge clk_clk); #1;
      if (bus.ram_write && bus.ram_address == 7'd40) found = 1;
    end
    reset_reset = 1'b1;
    @(posedge clk_clk); @(negedge clk_clk);
    n_checks++; if (found !== 1) $display("FAIL rmc_reach40: got %0d want 1", found); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmc_busy: got %b want 0", busy); else n_pass++;
    @(posedge clk_clk); #1 reset_reset = 1'b0;
    repeat (5) @(posedge clk_clk);
    @(negedge clk_clk);
    bad_lo = 0; bad_hi = 0;
    for (int a = 0; a < 40; a++) if (mem[a] !== 8'h00) bad_lo++;
    for (int a = 41; a < DEPTH; a++) if (mem[a] !== 8'hA5) bad_hi++;
    n_checks++; if (bad_lo !== 0) $display("FAIL rmc_cleared_lo: got %0d bad bins want 0", bad_lo); else n_pass++;
    n_checks++; if (bad_hi !== 0) $display("FAIL rmc_kept_hi: got %0d bad bins want 0", bad_hi); else n_pass++;
    n_checks++; if (done_cnt !== 0) $display("FAIL rmc_no_done: got %0d want 0", done_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int t0; acc_t r; gr_t g0, g1; acc_t w; exp_t e;
    do_reset; preload(50, 9);
    bus.hit_addr[1*ADDR_W +: ADDR_W] = 7'd50; bus.hit_addr[2*ADDR_W +: ADDR_W] = 7'd50;
    bus.hit_valid = 4'b0110; t0 = cyc;
    model[50] = 8'd10; exp_q.push_back('{50, 10});
    model[50] = 8'd11; exp_q.push_back('{50, 11});
    for (int i = 0; i < 20 && gr_q.size() < 2; i++) begin @(negedge clk_clk); #1; end
    @(posedge clk_clk); #1 bus.hit_valid = '0;
    for (int i = 0; i < 20 && wr_q.size() < 2; i++) begin @(negedge clk_clk); #1; end
    g0 = (gr_q.size() > 0) ? gr_q[0] : '{-1, '0};
    g1 = (gr_q.size() > 1) ? gr_q[1] : '{-1, '0};
    r  = (rd_q.size() > 1) ? rd_q[1] : '{-1, -1, -1};
    n_checks++; if (g0.cyc !== t0 || g0.vec !== 4'b0010) $display("FAIL b2b_grant0: got cyc %0d vec %b want cyc %0d vec 0010", g0.cyc, g0.vec, t0); else n_pass++;
    n_checks++; if (g1.cyc !== t0 + 2 || g1.vec !== 4'b0100) $display("FAIL b2b_grant1: got cyc %0d vec %b want cyc %0d vec 0100", g1.cyc, g1.vec, t0 + 2); else n_pass++;
    n_checks++; if (r.cyc !== t0 + 3 || r.addr !== 50) $display("FAIL b2b_read2: got cyc %0d addr %0d want cyc %0d addr 50", r.cyc, r.addr, t0 + 3); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      w = (wr_q.size() > 0) ? wr_q.pop_front() : '{-1, -1, -1};
      n_checks++; if (w.addr !== e.addr || w.data !== e.data) $display("FAIL b2b_sb: got %0d@%0d want %0d@%0d", w.data, w.addr, e.data, e.addr); else n_pass++;
    end
    @(negedge clk_clk);
    n_checks++; if (mem[50] !== 8'd11) $display("FAIL b2b_bin: got %0d want 11", mem[50]); else n_pass++;
    n_checks++; if (hit_count !== 32'd2) $display("FAIL b2b_hit_count: got %0d want 2", hit_count); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single_hit;
    test_round_robin;
    test_saturation;
    test_clear_during_rd;
    test_reset_mid_clear;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
